// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: req/ack handshake, LATENCY wait cycles, stall to hazard unit.
// Optional MEM_ERR_CHECK_EN macro enables misaligned / out-of-range access reporting on err_o.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          capture;
  logic          enter_done;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic          mem_we;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    capture    = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
            count_d = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (count_q == 4'd0) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero latency the access completes on the capture edge, so use the live inputs.
  assign acc_we    = capture ? we_i    : we_q;
  assign acc_addr  = capture ? addr_i  : addr_q;
  assign acc_wdata = capture ? wdata_i : wdata_q;
  assign acc_idx   = acc_addr[2 +: AW];

`ifdef MEM_ERR_CHECK_EN
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH_WORDS));
  endfunction

  assign acc_err = addr_bad(acc_addr);
  assign err_o   = (state_q == S_DONE) && addr_bad(addr_q);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:2+AW], acc_addr[1:0]};
  assign acc_err = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (enter_done) begin
      if (acc_err) begin
        rdata_d = 32'h0;
      end else if (!acc_we) begin
        rdata_d = mem_q[acc_idx];
      end
    end
  end

  assign mem_we  = enter_done && acc_we && !acc_err && !rst_i;
  assign ack_o   = (state_q == S_DONE);
  assign stall_o = req_i && !ack_o;
  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      if (capture) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  // Array contents survive reset; only the write strobe is reset-aware.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: unit 0 runs LATENCY=2, unit 1 runs LATENCY=0, against a word-array model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst   [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        stall [2];
  logic        err   [2];

  int n_checks = 0;
  int n_errors = 0;

`ifdef MEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Reference model: per-unit word array with written flags, expected read-data register.
  logic [31:0] mm       [2][256];
  bit          wr       [2][256];
  logic [31:0] exp_rd   [2];
  bit          rd_known [2];
  bit          skip     [2];

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .stall_o(stall[0]), .err_o(err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .stall_o(stall[1]), .err_o(err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
    return ERR_EN && ((a[1:0] != 2'b00) || (a >= 32'd1024));
  endfunction

  // Called at a falling edge with the responder either idle or in its ack cycle (skip[u]).
  task automatic access(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit drop, input bit hold);
    int          L;
    int          wi;
    bit          e;
    L  = lat(u);
    wi = int'(a[9:2]);
    e  = bad_addr(a);
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
    #1;
    check("stall_pre", {31'b0, stall[u]}, {31'b0, !skip[u]});
    if (skip[u]) begin
      @(posedge clk); #1;
      check("dead_ack", {31'b0, ack[u]}, 32'd0);
      check("dead_stall", {31'b0, stall[u]}, 32'd1);
    end
    @(posedge clk);
    if (e) begin
      exp_rd[u] = 32'h0; rd_known[u] = 1'b1;
    end else if (w) begin
      mm[u][wi] = d; wr[u][wi] = 1'b1;
    end else begin
      exp_rd[u] = mm[u][wi]; rd_known[u] = wr[u][wi];
    end
    for (int j = 0; j <= L; j++) begin
      #1;
      check("ack", {31'b0, ack[u]}, {31'b0, j == L});
      check("stall", {31'b0, stall[u]}, {31'b0, req[u] && (j != L)});
      if (j == L) begin
        check("err", {31'b0, err[u]}, {31'b0, e});
        if (rd_known[u]) check("rdata", rdata[u], exp_rd[u]);
      end
      if (j < L) begin
        @(negedge clk);
        if (j == 0) begin
          we[u] = 1'($urandom); addr[u] = $urandom; wdata[u] = $urandom;
          if (drop) req[u] = 1'b0;
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    if (!hold) begin
      req[u] = 1'b0;
      @(posedge clk); #1;
      check("ack_clr", {31'b0, ack[u]}, 32'd0);
      check("err_clr", {31'b0, err[u]}, 32'd0);
      @(negedge clk);
    end
    skip[u] = hold;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; req[u] = 1'b0; we[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
      exp_rd[u] = 32'h0; rd_known[u] = 1'b1; skip[u] = 1'b0;
      for (int i = 0; i < 256; i++) wr[u][i] = 1'b0;
    end
    #12;
    for (int u = 0; u < 2; u++) begin
      check("rst_ack", {31'b0, ack[u]}, 32'd0);
      check("rst_rdata", rdata[u], 32'd0);
      check("rst_err", {31'b0, err[u]}, 32'd0);
      check("rst_stall", {31'b0, stall[u]}, 32'd0);
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Store/load round trip, then a store with req dropped after capture.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1, 1'b0);
    access(0, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of a store abandons it.
    access(0, 1'b1, 32'h20, 32'h11111111, 1'b0, 1'b0);
    access(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
    @(posedge clk); #2;
    rst[0] = 1'b1;
    #1;
    check("midrst_ack", {31'b0, ack[0]}, 32'd0);
    check("midrst_rdata", rdata[0], 32'd0);
    @(posedge clk); #1;
    check("midrst_hold_ack", {31'b0, ack[0]}, 32'd0);
    @(negedge clk);
    rst[0] = 1'b0; req[0] = 1'b0;
    exp_rd[0] = 32'h0; rd_known[0] = 1'b1;
    access(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);

    // Index wrap (or error), and a misaligned load.
    access(0, 1'b1, 32'h000, 32'h0BADF00D, 1'b0, 1'b0);
    access(0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0, 1'b0);
    access(0, 1'b0, 32'h000, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

    // Zero latency: request held through the ack is served once more after a dead cycle.
    access(1, 1'b1, 32'h10, 32'h600DCAFE, 1'b0, 1'b0);
    access(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
    access(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 40; n++) begin
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) a = $urandom & 32'h0000_07FF;
        else a = 32'($urandom_range(0, 7)) << 2;
        access(u, 1'($urandom), a, $urandom, ($urandom_range(0, 3) == 0),
               (n != 39) && ($urandom_range(0, 2) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
